// File: rtl/video_timing.sv
// Pixel-clock sequencer for the attribute/pixel stage: phase/column/line counters,
// screen-memory fetch addressing, per-cell strobes, blanking and syncs.
module video_timing #(
  parameter int unsigned PIX_PER_CHAR   = 6,
  parameter int unsigned CHARS_PER_LINE = 64,
  parameter int unsigned VIS_CHARS      = 40,
  parameter int unsigned VIS_LINES      = 224,
  parameter int unsigned HIRES_LINES    = 200,
  parameter int unsigned LINES_50       = 312,
  parameter int unsigned LINES_60       = 264,
  parameter int unsigned VS_50          = 256,
  parameter int unsigned VS_60          = 236,
  parameter int unsigned HS_START       = 49
) (
  input  logic        CLK_PIXEL,
  input  logic        RESETn,
  input  logic        FREQ_SEL,
  input  logic        TXTHIR_SEL,
  input  logic        DBLSTD_SEL,
  input  logic        isAttrib,
  output logic [2:0]  PHASE,
  output logic [5:0]  COLUMN,
  output logic [8:0]  LINE,
  output logic [2:0]  CHROWCNT,
  output logic [15:0] VAP1,
  output logic        VAP_SEL,
  output logic        DATABUS_EN,
  output logic        ATTRIB_DEC,
  output logic        LDFROMBUS,
  output logic        LD_REG_0,
  output logic        RELD_REG,
  output logic        RELOAD_SEL,
  output logic        BLANKINGn,
  output logic        HSYNCn,
  output logic        VSYNCn
);

  localparam logic [2:0] LastPhase   = 3'(PIX_PER_CHAR - 1);
  localparam logic [5:0] LastCol     = 6'(CHARS_PER_LINE - 1);
  localparam logic [5:0] VisChars    = 6'(VIS_CHARS);
  localparam logic [8:0] VisLines    = 9'(VIS_LINES);
  localparam logic [8:0] HiresLines  = 9'(HIRES_LINES);
  localparam logic [8:0] Last50      = 9'(LINES_50 - 1);
  localparam logic [8:0] Last60      = 9'(LINES_60 - 1);
  localparam logic [8:0] Vs50        = 9'(VS_50);
  localparam logic [8:0] Vs60        = 9'(VS_60);
  localparam logic [5:0] HsFirst     = 6'(HS_START);
  localparam logic [5:0] HsLast      = 6'(HS_START + 3);
  localparam logic [8:0] PixPerChar9 = 9'(PIX_PER_CHAR);
  // Blanking window in pixel index within the line, delayed one cycle to match the shifter.
  localparam logic [8:0] BlankOn     = 9'(PIX_PER_CHAR + 1);
  localparam logic [8:0] BlankOff    = 9'((VIS_CHARS + 1) * PIX_PER_CHAR);

  logic [2:0]  phase_q, phase_d;
  logic [5:0]  column_q, column_d;
  logic [8:0]  line_q, line_d;
  logic        run_q, freq_q, freq_d;
  logic        txthir_q, txthir_d, hires_q, hires_d;
  logic [2:0]  chrow_q, chrow_d;
  logic [15:0] vap1_q, vap1_d;
  logic        de0_q, de0_d, ad_q, ad_d, win2_q, win2_d;
  logic        ldfb_q, ldfb_d, ld0_q, ld0_d, vap3_q, vap3_d;
  logic        reld_q, reld_d, reload_q, reload_d;
  logic        blank_n_q, blank_n_d, hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;

  logic        phase_wrap, column_wrap, frame_wrap;
  logic [8:0]  last_line;

  // Counters; the cycle after reset release repeats position 0 so it is the first active cell.
  always_comb begin
    last_line   = freq_q ? Last60 : Last50;
    phase_wrap  = (phase_q == LastPhase);
    column_wrap = phase_wrap && (column_q == LastCol);
    frame_wrap  = column_wrap && (line_q == last_line);
    phase_d     = '0;
    column_d    = '0;
    line_d      = '0;
    freq_d      = freq_q;
    if (run_q) begin
      phase_d  = phase_wrap ? 3'd0 : phase_q + 3'd1;
      column_d = column_q;
      line_d   = line_q;
      if (phase_wrap) column_d = column_wrap ? 6'd0 : column_q + 6'd1;
      if (column_wrap) line_d = frame_wrap ? 9'd0 : line_q + 9'd1;
      if (frame_wrap) freq_d = FREQ_SEL;
    end
  end

  logic        cell_start, split_d, active_d, ph_is_0, ph_is_1, ph_is_2, ph_is_3, ph_is_5;
  logic [8:0]  trow_line, pix_idx, vs_first;
  logic [5:0]  trow;
  logic [15:0] row_base, row_off, addr_base;

  // Registered outputs are computed from the next position so they line up with the counters.
  always_comb begin
    cell_start = (phase_d == 3'd0) && (column_d == 6'd0);
    txthir_d   = cell_start ? TXTHIR_SEL : txthir_q;
    hires_d    = cell_start ? (TXTHIR_SEL && (line_d < HiresLines)) : hires_q;

    split_d   = txthir_d && (line_d >= HiresLines) && (line_d < VisLines);
    trow_line = split_d ? (line_d - HiresLines) : line_d;
    trow      = 6'(trow_line >> 3);
    row_base  = hires_d ? {7'd0, line_d} : {10'd0, trow};
    row_off   = (row_base << 5) + (row_base << 3);
    addr_base = hires_d ? 16'hA000 : (split_d ? 16'hBF68 : 16'hBB80);
    vap1_d    = addr_base + row_off + {10'd0, column_d};
    chrow_d   = DBLSTD_SEL ? {trow[0], line_d[2:1]} : line_d[2:0];

    active_d = (column_d < VisChars) && (line_d < VisLines);
    ph_is_0  = (phase_d == 3'd0);
    ph_is_1  = (phase_d == 3'd1);
    ph_is_2  = (phase_d == 3'd2);
    ph_is_3  = (phase_d == 3'd3);
    ph_is_5  = (phase_d == 3'd5);
    de0_d    = active_d && ph_is_0;
    ad_d     = active_d && ph_is_1;
    win2_d   = active_d && ph_is_2 && !hires_d;
    // isAttrib is valid during phase 2, which is when the phase-3 strobes are computed.
    ldfb_d   = active_d && ph_is_3 && !isAttrib;
    ld0_d    = ph_is_3 && (!active_d || isAttrib);
    vap3_d   = ldfb_d && !hires_d;
    reld_d   = ph_is_5;
    reload_d = ph_is_5 && (column_d == LastCol);

    pix_idx   = ({3'd0, column_d} * PixPerChar9) + {6'd0, phase_d};
    blank_n_d = (line_d < VisLines) && (pix_idx >= BlankOn) && (pix_idx <= BlankOff);
    hsync_n_d = !((column_d >= HsFirst) && (column_d <= HsLast));
    vs_first  = freq_d ? Vs60 : Vs50;
    vsync_n_d = !((line_d >= vs_first) && (line_d <= vs_first + 9'd3));
  end

  always_ff @(posedge CLK_PIXEL) begin
    if (!RESETn) begin
      phase_q   <= '0;
      column_q  <= '0;
      line_q    <= '0;
      run_q     <= 1'b0;
      freq_q    <= 1'b0;
      txthir_q  <= 1'b0;
      hires_q   <= 1'b0;
      chrow_q   <= '0;
      vap1_q    <= 16'hBB80;
      de0_q     <= 1'b0;
      ad_q      <= 1'b0;
      win2_q    <= 1'b0;
      ldfb_q    <= 1'b0;
      ld0_q     <= 1'b0;
      vap3_q    <= 1'b0;
      reld_q    <= 1'b0;
      reload_q  <= 1'b0;
      blank_n_q <= 1'b0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
    end else begin
      phase_q   <= phase_d;
      column_q  <= column_d;
      line_q    <= line_d;
      run_q     <= 1'b1;
      freq_q    <= freq_d;
      txthir_q  <= txthir_d;
      hires_q   <= hires_d;
      chrow_q   <= chrow_d;
      vap1_q    <= vap1_d;
      de0_q     <= de0_d;
      ad_q      <= ad_d;
      win2_q    <= win2_d;
      ldfb_q    <= ldfb_d;
      ld0_q     <= ld0_d;
      vap3_q    <= vap3_d;
      reld_q    <= reld_d;
      reload_q  <= reload_d;
      blank_n_q <= blank_n_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
    end
  end

  // The phase-2 second fetch is cancelled by the live attribute flag, valid only from phase 2.
  logic fetch2;
  assign fetch2     = win2_q && !isAttrib;
  assign PHASE      = phase_q;
  assign COLUMN     = column_q;
  assign LINE       = line_q;
  assign CHROWCNT   = chrow_q;
  assign VAP1       = vap1_q;
  assign VAP_SEL    = fetch2 || vap3_q;
  assign DATABUS_EN = de0_q || fetch2;
  assign ATTRIB_DEC = ad_q;
  assign LDFROMBUS  = ldfb_q;
  assign LD_REG_0   = ld0_q;
  assign RELD_REG   = reld_q;
  assign RELOAD_SEL = reload_q;
  assign BLANKINGn  = blank_n_q;
  assign HSYNCn     = hsync_n_q;
  assign VSYNCn     = vsync_n_q;

endmodule

// File: tb/tb_video_timing.sv
// Randomized scoreboard bench for video_timing; the frame is shortened vertically so
// several frame wraps (50 Hz and 60 Hz) fit in one run.
module tb_video_timing;

  localparam int unsigned PixPerChar   = 6;
  localparam int unsigned CharsPerLine = 64;
  localparam int unsigned VisChars     = 40;
  localparam int unsigned VisLines     = 24;
  localparam int unsigned HiresLines   = 16;
  localparam int unsigned Lines50      = 32;
  localparam int unsigned Lines60      = 28;
  localparam int unsigned Vs50         = 27;
  localparam int unsigned Vs60         = 24;
  localparam int unsigned HsStart      = 49;
  localparam int unsigned LineCycles   = PixPerChar * CharsPerLine;
  localparam int          RunCycles    = 40000;
  localparam int          MaxBad       = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0, freq_sel = 1'b0, txthir = 1'b0, dblstd = 1'b0, is_attrib = 1'b0;
  logic [2:0]  PHASE, CHROWCNT;
  logic [5:0]  COLUMN;
  logic [8:0]  LINE;
  logic [15:0] VAP1;
  logic VAP_SEL, DATABUS_EN, ATTRIB_DEC, LDFROMBUS, LD_REG_0, RELD_REG, RELOAD_SEL;
  logic BLANKINGn, HSYNCn, VSYNCn;

  always #5 clk = ~clk;

  video_timing #(
    .PIX_PER_CHAR  (PixPerChar),
    .CHARS_PER_LINE(CharsPerLine),
    .VIS_CHARS     (VisChars),
    .VIS_LINES     (VisLines),
    .HIRES_LINES   (HiresLines),
    .LINES_50      (Lines50),
    .LINES_60      (Lines60),
    .VS_50         (Vs50),
    .VS_60         (Vs60),
    .HS_START      (HsStart)
  ) dut (
    .CLK_PIXEL (clk),
    .RESETn    (rst_n),
    .FREQ_SEL  (freq_sel),
    .TXTHIR_SEL(txthir),
    .DBLSTD_SEL(dblstd),
    .isAttrib  (is_attrib),
    .PHASE     (PHASE),
    .COLUMN    (COLUMN),
    .LINE      (LINE),
    .CHROWCNT  (CHROWCNT),
    .VAP1      (VAP1),
    .VAP_SEL   (VAP_SEL),
    .DATABUS_EN(DATABUS_EN),
    .ATTRIB_DEC(ATTRIB_DEC),
    .LDFROMBUS (LDFROMBUS),
    .LD_REG_0  (LD_REG_0),
    .RELD_REG  (RELD_REG),
    .RELOAD_SEL(RELOAD_SEL),
    .BLANKINGn (BLANKINGn),
    .HSYNCn    (HSYNCn),
    .VSYNCn    (VSYNCn)
  );

  typedef struct packed {
    logic [2:0]  phase;
    logic [5:0]  column;
    logic [8:0]  line;
    logic [2:0]  chrow;
    logic [15:0] vap1;
    logic        vap_sel, de, ad, ldfb, ld0, reld, reload, blank_n, hsync_n, vsync_n;
  } outs_t;

  outs_t exp_q[$];
  bit    rst_exp_q[$];
  int    total = 0;
  int    bad = 0;

  outs_t got;
  assign got = {PHASE, COLUMN, LINE, CHROWCNT, VAP1, VAP_SEL, DATABUS_EN, ATTRIB_DEC,
                LDFROMBUS, LD_REG_0, RELD_REG, RELOAD_SEL, BLANKINGn, HSYNCn, VSYNCn};

  function automatic outs_t reset_outs();
    outs_t o;
    o = '0;
    o.vap1 = 16'hBB80;
    o.hsync_n = 1'b1;
    o.vsync_n = 1'b1;
    return o;
  endfunction

  // Expected outputs at absolute cycle idx of the frame, straight from the display rules.
  function automatic outs_t model_outs(int idx, bit freq, bit line_tx, bit dbl, bit attr);
    outs_t o;
    int line, x, col, ph, trow, vs, addr;
    bit active, hires, split;
    line   = idx / LineCycles;
    x      = idx % LineCycles;
    col    = x / PixPerChar;
    ph     = x % PixPerChar;
    active = (col < VisChars) && (line < VisLines);
    hires  = line_tx && (line < HiresLines);
    split  = line_tx && (line >= HiresLines) && (line < VisLines);
    trow   = split ? (line - HiresLines) / 8 : line / 8;
    if (hires) addr = 'hA000 + line * 40 + col;
    else addr = (split ? 'hBF68 : 'hBB80) + trow * 40 + col;
    vs = freq ? Vs60 : Vs50;
    o = '0;
    o.phase   = 3'(ph);
    o.column  = 6'(col);
    o.line    = 9'(line);
    o.chrow   = dbl ? 3'((trow % 2) * 4 + (line / 2) % 4) : 3'(line % 8);
    o.vap1    = 16'(addr);
    o.de      = active && (ph == 0 || (ph == 2 && !hires && !attr));
    o.ad      = active && ph == 1;
    o.vap_sel = active && !hires && !attr && (ph == 2 || ph == 3);
    o.ldfb    = active && ph == 3 && !attr;
    o.ld0     = (ph == 3) && !(active && !attr);
    o.reld    = (ph == PixPerChar - 1);
    o.reload  = (ph == PixPerChar - 1) && (col == CharsPerLine - 1);
    o.blank_n = (line < VisLines) && (x >= 1 * PixPerChar + 0 + 1) &&
                (x <= VisChars * PixPerChar + (PixPerChar - 1) + 1);
    o.hsync_n = !((col >= HsStart) && (col < HsStart + 4));
    o.vsync_n = !((line >= vs) && (line < vs + 4));
    return o;
  endfunction

  // Stimulus and reference model; expectations for each cycle go to the scoreboard queue.
  initial begin
    int  m_idx, ph, rst_at;
    bit  m_freq, m_in_rst, m_line_tx, m_attr, dbl_prev;
    m_idx = 0;
    m_freq = 1'b0;
    m_in_rst = 1'b1;
    m_line_tx = 1'b0;
    m_attr = 1'b0;
    rst_at = 1500 + int'($urandom_range(0, 300));
    for (int cyc = 0; cyc < RunCycles && bad < MaxBad; cyc++) begin
      @(posedge clk);
      #1;
      // Inputs still hold what the DUT just sampled at this edge.
      dbl_prev = dblstd;
      if (!rst_n) begin
        m_in_rst = 1'b1;
        m_idx = 0;
        m_freq = 1'b0;
      end else if (m_in_rst) begin
        m_in_rst = 1'b0;
        m_idx = 0;
        m_line_tx = txthir;
      end else begin
        m_idx++;
        if (m_idx == (m_freq ? Lines60 : Lines50) * LineCycles) begin
          m_idx = 0;
          m_freq = freq_sel;
        end
        if (m_idx % LineCycles == 0) m_line_tx = txthir;
      end

      rst_n = !(cyc < 3 || (cyc >= rst_at && cyc < rst_at + 2));
      freq_sel = (cyc >= 4000 && cyc < 20000);
      if ($urandom_range(0, 1499) == 0) txthir = !txthir;
      if ($urandom_range(0, 699) == 0) dblstd = !dblstd;
      ph = m_idx % PixPerChar;
      if (m_in_rst || ph < 2) begin
        is_attrib = 1'($urandom_range(0, 1));
      end else begin
        if (ph == 2) m_attr = ($urandom_range(0, 2) == 0);
        is_attrib = m_attr;
      end

      exp_q.push_back(m_in_rst ? reset_outs() : model_outs(m_idx, m_freq, m_line_tx, dbl_prev,
                                                           m_attr));
      rst_exp_q.push_back(m_in_rst);
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  task automatic check_count(input string name, input int got_v, input int want_v);
    total++;
    if (got_v != want_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, got_v, want_v);
    end
  endtask

  int hs_cnt = 0, bl_cnt = 0, rl_cnt = 0;
  bit line_ok = 1'b0;

  always @(negedge clk) begin
    outs_t e;
    bit    in_rst;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      in_rst = rst_exp_q.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL outputs t=%0t line=%0d col=%0d ph=%0d: got %h want %h (diff %h)",
                 $time, e.line, e.column, e.phase, got, e, got ^ e);
      end
      if (in_rst) begin
        line_ok = 1'b0;
      end else begin
        if (e.column == 0 && e.phase == 0) begin
          line_ok = 1'b1;
          hs_cnt = 0;
          bl_cnt = 0;
          rl_cnt = 0;
        end
        if (!HSYNCn) hs_cnt++;
        if (BLANKINGn) bl_cnt++;
        if (RELOAD_SEL) rl_cnt++;
        if (line_ok && e.column == CharsPerLine - 1 && e.phase == PixPerChar - 1) begin
          check_count("hsync_low_cycles", hs_cnt, 4 * PixPerChar);
          check_count("blank_high_cycles", bl_cnt,
                      (e.line < VisLines) ? VisChars * PixPerChar : 0);
          check_count("reload_pulses", rl_cnt, 1);
        end
      end
    end
  end

endmodule

// File: doc/video_timing.md
Name: video_timing

Overview:
Upstream sequencer for the attribute/pixel stage (videov). It runs on the pixel clock and drives everything that stage needs each line and frame:
- char/line counters, CHROWCNT and the screen-memory address VAP1
- the per-character strobe sequence: DATABUS_EN, ATTRIB_DEC, LDFROMBUS, LD_REG_0, RELD_REG, RELOAD_SEL
- blanking and syncs

It consumes FREQ_SEL, TXTHIR_SEL, DBLSTD_SEL and isAttrib back from that stage. All strobes are registered, single-cycle active-high pulses.

Parameters:
PIX_PER_CHAR, 6, pixel clocks per character cell (phase 0..5)
CHARS_PER_LINE, 64, character cells per line (64 us line at 1 MHz cell rate)
VIS_CHARS, 40, displayed cells per line
VIS_LINES, 224, displayed lines (28 text rows x 8)
HIRES_LINES, 200, lines using bitmap fetch when hires mode is active
LINES_50, 312, lines per frame when FREQ_SEL=0
LINES_60, 264, lines per frame when FREQ_SEL=1
VS_50, 256, first VSYNC line at 50 Hz
VS_60, 236, first VSYNC line at 60 Hz
HS_START, 49, first HSYNC column (HSYNC is 4 columns wide)

Ports:
CLK_PIXEL  in  1  6 MHz pixel clock; the only clock
RESETn  in  1  synchronous reset, active low
FREQ_SEL  in  1  0=50 Hz, 1=60 Hz frame length
TXTHIR_SEL  in  1  1=hires mode requested
DBLSTD_SEL  in  1  1=double-height text
isAttrib  in  1  registered attribute flag; valid from phase 2
PHASE  out  3  pixel phase within cell, 0..5
COLUMN  out  6  cell column 0..63
LINE  out  9  line within frame
CHROWCNT  out  3  character-generator row
VAP1  out  16  phase-0 fetch address (char code or bitmap byte)
VAP_SEL  out  1  1 = external mux puts VAP2 on the bus
DATABUS_EN  out  1  bus-latch strobe
ATTRIB_DEC  out  1  attribute-decode strobe
LDFROMBUS  out  1  hold-register load strobe
LD_REG_0  out  1  hold-register clear strobe
RELD_REG  out  1  shifter-load strobe
RELOAD_SEL  out  1  end-of-line attribute reset
BLANKINGn  out  1  1 = active video
HSYNCn  out  1  horizontal sync, active low
VSYNCn  out  1  vertical sync, active low

Behaviour:
Counters
- PHASE counts 0..5 and wraps.
- COLUMN increments when PHASE wraps, and wraps 63→0.
- LINE increments when COLUMN wraps, and wraps at last line → 0.
- Last line is LINES_60-1 or LINES_50-1. FREQ_SEL is sampled only at LINE=last, COLUMN=63, PHASE=5; a mid-frame change never truncates or extends the current frame.

Line mode
- hires_line is latched at COLUMN=0, PHASE=0: hires_line = TXTHIR_SEL & (LINE<200).
- A mode change mid-line takes effect on the next line.

Text row and CHROWCNT
- trow = LINE>>3 in text mode. In hires mode, trow = (LINE-200)>>3 for lines 200..223.
- CHROWCNT = DBLSTD_SEL ? {trow[0], LINE[2:1]} : LINE[2:0].

Address
- hires_line: VAP1 = 0xA000 + LINE*40 + COLUMN.
- TXTHIR_SEL=1 and LINE in 200..223: VAP1 = 0xBF68 + trow*40 + COLUMN.
- Otherwise: VAP1 = 0xBB80 + trow*40 + COLUMN.
- x*40 is implemented as (x<<5)+(x<<3); all results are 16-bit.
- VAP1 is registered and stable from PHASE=0 of the cell.

Strobes (only when COLUMN<40 and LINE<224, except RELOAD_SEL)
- PHASE 0: DATABUS_EN.
- PHASE 1: ATTRIB_DEC.
- PHASE 2:
  - text line and isAttrib=0: VAP_SEL=1 for PHASE 2..3, plus DATABUS_EN.
  - hires line or isAttrib=1: no second fetch.
- PHASE 3: LDFROMBUS if isAttrib=0, else LD_REG_0. The two are never asserted together.
- PHASE 5: RELD_REG.
- Outside the active window, PHASE 3 asserts LD_REG_0 and PHASE 5 asserts RELD_REG, so the shifter drains zeros.
- RELOAD_SEL pulses every line at COLUMN=63, PHASE=5, including blank lines.

Blanking and sync
- BLANKINGn is high one cycle after PHASE=0 of COLUMN 1, through COLUMN 40 PHASE 5 plus one cycle, on lines 0..223. This aligns with shifter output.
- HSYNCn is low for COLUMN 49..52.
- VSYNCn is low for lines VS..VS+3, where VS follows the latched frequency.

Reset (RESETn low at a clock edge)
- PHASE, COLUMN, LINE = 0.
- All strobes and VAP_SEL = 0.
- BLANKINGn = 0; HSYNCn and VSYNCn = 1.
- VAP1 = 0xBB80; CHROWCNT = 0; latched frequency = 50 Hz.
- Reset mid-line aborts the current sequence immediately.
- The first cycle after release is PHASE=0, COLUMN=0, LINE=0.

Test Plan:
1. Reset mid-line, release → PHASE/COLUMN/LINE=0, VAP1=0xBB80, all strobes 0, syncs high; first DATABUS_EN at cycle 0 after release.
2. Text line 0, isAttrib=0 → per cell: DATABUS_EN at phases 0 and 2, ATTRIB_DEC at 1, VAP_SEL at 2..3, LDFROMBUS at 3, RELD_REG at 5. LINE=8, COLUMN=1 → VAP1=0xBBA9.
3. isAttrib=1 at phase 2 → no second DATABUS_EN, VAP_SEL=0, LD_REG_0 at phase 3, LDFROMBUS=0.
4. TXTHIR_SEL=1 → line 199 col 39 VAP1=0xBF3F with single fetch; line 200 col 0 VAP1=0xBF68, second fetch resumes. DBLSTD_SEL=1 on line 13 → CHROWCNT=3'b110.
5. FREQ_SEL 0→1 at line 100 → frame still ends at 311; next frame wraps after line 263; VSYNCn low on lines 236..239.
6. Line end → RELOAD_SEL once at COLUMN=63 PHASE=5; HSYNCn low exactly 24 cycles; BLANKINGn high exactly 240 cycles per visible line, 0 on line 224.
